vector_load_sequencer: RTL and testbench
========================================

// Module: vector_load_sequencer
// PURPOSE
//  Transmit side of the vector CPU's pixel/constant load port. On start, reads 8 pixel words
//  and 8 multiplier-constant words from a word-addressed source memory and drives them into
//  the CPU as two 4-lane pixel writes (slots 0,1) then two 4-lane constant writes (slots 0,1).
//  Sits between the image/constant RAM and the vector CPU's we_pxl/wdp*, we_mul/wdm* inputs.
// PARAMETERS
//  ADDR_W  16  source memory address width (words)
//  DATA_W  32  lane / memory word width
// PORTS
//  clk            in   1       clock, all logic on rising edge
//  rst            in   1       synchronous reset, active-low
//  start          in   1       begin one load sequence (sampled only in IDLE)
//  pxl_base       in   ADDR_W  address of first pixel word (sampled with start)
//  mul_base       in   ADDR_W  address of first constant word (sampled with start)
//  busy           out  1       sequence in progress
//  done           out  1       one-cycle pulse after final constant write
//  mem_re         out  1       memory read enable
//  mem_addr       out  ADDR_W  memory read address
//  mem_rdata      in   DATA_W  read data, valid exactly 1 cycle after mem_re
//  we_pxl         out  1       pixel slot write strobe to CPU
//  wr_pos_pxl     out  1       pixel slot select (0/1)
//  wdp1..wdp4     out  DATA_W  pixel lanes 1..4
//  we_mul         out  1       constant slot write strobe to CPU
//  wr_mul_pos_in  out  1       constant slot select (0/1)
//  wdm1..wdm4     out  DATA_W  constant lanes 1..4
// BEHAVIOUR
//  - Reset (rst==0 at edge): state IDLE; every output 0; lane/address/counter regs 0.
//  - FSM: IDLE -> FETCH (start==1) -> DRAIN (16th read issued) -> DONE (last strobe) -> IDLE.
//  - Cycle 0 = first cycle after start sampled. busy=1 cycles 0..17; done=1 in cycle 18 only.
//  - Read issue k=0..15 in cycle k: mem_re=1, mem_addr = pxl_base+k (k<8), mul_base+(k-8) (k>=8).
//    Address arithmetic modulo 2^ADDR_W (wraps silently). mem_re=0 outside cycles 0..15.
//  - mem_rdata in cycle k+1 captured into lane (k mod 4); word k mod 4 = 0 -> lane 1.
//  - When k mod 4 == 3: at end of cycle k+1 load all four lanes (incl. current rdata) into the
//    wdp*/wdm* output regs; strobe high for exactly cycle k+2 with slot = (k/4) mod 2.
//    Resulting strobes: we_pxl cycles 5 (slot 0), 9 (slot 1); we_mul cycles 13 (0), 17 (1).
//  - we_pxl and we_mul never high together. wr_pos_pxl/wr_mul_pos_in hold value until next load.
//  - wdp*/wdm* hold last written group after the strobe (not cleared) until reset.
//  - start while busy or in DONE: ignored (no queueing). start in same cycle done=1: ignored;
//    start in cycle 19 accepted, next sequence cycle 0 = cycle 20.
//  - pxl_base/mul_base registered at start; input changes mid-sequence have no effect.
//  - Overlapping regions (mul_base within pxl range) permitted; words simply read twice.
//  - Reset mid-sequence: aborts immediately, no further strobes, outputs to reset values.
// TESTING
//  1 Reset: rst=0 two cycles -> busy,done,mem_re,we_pxl,we_mul=0, all wdp*/wdm*=0.
//  2 Full load: mem[0..3]=416D5267,416D5263,415D5267,426D5267; mem[4..7]=416D5367,416C5263,
//    415D5267,426D506B; mem[100..107]=mem[0..3] twice; start pxl_base=0 mul_base='h100 ->
//    we_pxl cycle 5 slot0 wdp1..4=mem[0..3], cycle 9 slot1 =mem[4..7]; we_mul cycles 13,17
//    slots 0,1 wdm=416D5267,416D5263,415D5267,426D5267; done cycle 18; 16 reads addr correct.
//  3 start pulsed at cycles 3 and 18 -> ignored; start cycle 19 -> second sequence, busy from 20.
//  4 pxl_base='hFFFC -> mem_addr FFFC..FFFF then 0000..0003 for pixel reads (wrap).
//  5 rst=0 in cycle 7 -> cycle 8 all outputs 0, no we_pxl at cycle 9; later start runs clean.
//  6 Change pxl_base/mul_base during cycles 1..15 -> addresses unchanged from sampled values.

Source files
------------

// File: rtl/vector_load_sequencer.sv
// Load-port sequencer: fetches 8 pixel words and 8 constant words from source memory and
// drives them to the vector CPU as two pixel-slot writes followed by two constant-slot writes.
module vector_load_sequencer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pxl_base,
  input  logic [ADDR_W-1:0] mul_base,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              we_pxl,
  output logic              wr_pos_pxl,
  output logic [DATA_W-1:0] wdp1,
  output logic [DATA_W-1:0] wdp2,
  output logic [DATA_W-1:0] wdp3,
  output logic [DATA_W-1:0] wdp4,
  output logic              we_mul,
  output logic              wr_mul_pos_in,
  output logic [DATA_W-1:0] wdm1,
  output logic [DATA_W-1:0] wdm2,
  output logic [DATA_W-1:0] wdm3,
  output logic [DATA_W-1:0] wdm4
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        rd_cnt_q;
  logic [ADDR_W-1:0] pxl_q, mul_q;
  logic              rd_vld_q;
  logic [3:0]        rd_idx_q;
  logic [DATA_W-1:0] lane1_q, lane2_q, lane3_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Reads 0..7 walk the pixel region, reads 8..15 the constant region.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    mem_re   = 1'b0;
    mem_addr = '0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy     = 1'b1;
        mem_re   = 1'b1;
        mem_addr = rd_cnt_q[3] ? mul_q + ADDR_W'(rd_cnt_q[2:0])
                               : pxl_q + ADDR_W'(rd_cnt_q[2:0]);
        if (rd_cnt_q == 4'd15) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (we_mul && wr_mul_pos_in) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data trails mem_re by one cycle; the fourth word of each group is forwarded
  // straight from mem_rdata into the output lanes together with the three held ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_cnt_q      <= '0;
      pxl_q         <= '0;
      mul_q         <= '0;
      rd_vld_q      <= 1'b0;
      rd_idx_q      <= '0;
      lane1_q       <= '0;
      lane2_q       <= '0;
      lane3_q       <= '0;
      we_pxl        <= 1'b0;
      wr_pos_pxl    <= 1'b0;
      wdp1          <= '0;
      wdp2          <= '0;
      wdp3          <= '0;
      wdp4          <= '0;
      we_mul        <= 1'b0;
      wr_mul_pos_in <= 1'b0;
      wdm1          <= '0;
      wdm2          <= '0;
      wdm3          <= '0;
      wdm4          <= '0;
    end else begin
      we_pxl   <= 1'b0;
      we_mul   <= 1'b0;
      rd_vld_q <= mem_re;
      rd_idx_q <= rd_cnt_q;
      if (state_q == S_IDLE && start) begin
        pxl_q    <= pxl_base;
        mul_q    <= mul_base;
        rd_cnt_q <= '0;
      end else if (state_q == S_FETCH) begin
        rd_cnt_q <= rd_cnt_q + 4'd1;
      end
      if (rd_vld_q) begin
        case (rd_idx_q[1:0])
          2'd0: lane1_q <= mem_rdata;
          2'd1: lane2_q <= mem_rdata;
          2'd2: lane3_q <= mem_rdata;
          default: begin
            if (!rd_idx_q[3]) begin
              we_pxl     <= 1'b1;
              wr_pos_pxl <= rd_idx_q[2];
              wdp1       <= lane1_q;
              wdp2       <= lane2_q;
              wdp3       <= lane3_q;
              wdp4       <= mem_rdata;
            end else begin
              we_mul        <= 1'b1;
              wr_mul_pos_in <= rd_idx_q[2];
              wdm1          <= lane1_q;
              wdm2          <= lane2_q;
              wdm3          <= lane3_q;
              wdm4          <= mem_rdata;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vector_load_sequencer.sv
// Self-checking bench for vector_load_sequencer: a cycle-indexed reference model derived from
// the load schedule is compared against the DUT every cycle of each sequence.
module tb_vector_load_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pxl_base = '0;
  logic [15:0] mul_base = '0;
  logic        busy, done, mem_re;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        we_pxl, wr_pos_pxl, we_mul, wr_mul_pos_in;
  logic [31:0] wdp1, wdp2, wdp3, wdp4, wdm1, wdm2, wdm3, wdm4;

  logic [31:0] mem [0:65535];
  logic [31:0] exp_wdp [4];
  logic [31:0] exp_wdm [4];
  logic        exp_pos_pxl, exp_pos_mul;
  int          checks = 0;
  int          failures = 0;

  vector_load_sequencer #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .pxl_base(pxl_base), .mul_base(mul_base),
    .busy(busy), .done(done), .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .we_pxl(we_pxl), .wr_pos_pxl(wr_pos_pxl),
    .wdp1(wdp1), .wdp2(wdp2), .wdp3(wdp3), .wdp4(wdp4),
    .we_mul(we_mul), .wr_mul_pos_in(wr_mul_pos_in),
    .wdm1(wdm1), .wdm2(wdm2), .wdm3(wdm3), .wdm4(wdm4)
  );

  always #5 clk = ~clk;

  // Source memory: one-cycle read latency.
  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic clearExpected();
    for (int i = 0; i < 4; i++) begin
      exp_wdp[i] = '0;
      exp_wdm[i] = '0;
    end
    exp_pos_pxl = 1'b0;
    exp_pos_mul = 1'b0;
  endtask

  task automatic checkLanes(input string tag);
    checkOutput({tag, ".wdp1"}, wdp1, exp_wdp[0]);
    checkOutput({tag, ".wdp2"}, wdp2, exp_wdp[1]);
    checkOutput({tag, ".wdp3"}, wdp3, exp_wdp[2]);
    checkOutput({tag, ".wdp4"}, wdp4, exp_wdp[3]);
    checkOutput({tag, ".wdm1"}, wdm1, exp_wdm[0]);
    checkOutput({tag, ".wdm2"}, wdm2, exp_wdm[1]);
    checkOutput({tag, ".wdm3"}, wdm3, exp_wdm[2]);
    checkOutput({tag, ".wdm4"}, wdm4, exp_wdm[3]);
    checkOutput({tag, ".pos_pxl"}, wr_pos_pxl, exp_pos_pxl);
    checkOutput({tag, ".pos_mul"}, wr_mul_pos_in, exp_pos_mul);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".busy"}, busy, 1'b0);
    checkOutput({tag, ".done"}, done, 1'b0);
    checkOutput({tag, ".mem_re"}, mem_re, 1'b0);
    checkOutput({tag, ".we_pxl"}, we_pxl, 1'b0);
    checkOutput({tag, ".we_mul"}, we_mul, 1'b0);
    checkLanes(tag);
  endtask

  // Expected behaviour for sequence cycle c given the sampled bases p and m.
  task automatic checkCycle(input int c, input logic [15:0] p, input logic [15:0] m);
    string       tag;
    logic [15:0] grp_base;
    logic [15:0] exp_addr;
    int          g;
    tag = $sformatf("c%0d", c);
    if (c == 5 || c == 9 || c == 13 || c == 17) begin
      g = (c - 5) / 4;
      grp_base = (g < 2) ? 16'(p + 4 * g) : 16'(m + 4 * (g - 2));
      for (int i = 0; i < 4; i++) begin
        if (g < 2) exp_wdp[i] = mem[16'(grp_base + i)];
        else       exp_wdm[i] = mem[16'(grp_base + i)];
      end
      if (g < 2) exp_pos_pxl = g[0];
      else       exp_pos_mul = g[0];
    end
    checkOutput({tag, ".busy"}, busy, c <= 17);
    checkOutput({tag, ".done"}, done, c == 18);
    checkOutput({tag, ".mem_re"}, mem_re, c <= 15);
    if (c <= 15) begin
      exp_addr = (c < 8) ? 16'(p + c) : 16'(m + c - 8);
      checkOutput({tag, ".mem_addr"}, mem_addr, exp_addr);
    end
    checkOutput({tag, ".we_pxl"}, we_pxl, c == 5 || c == 9);
    checkOutput({tag, ".we_mul"}, we_mul, c == 13 || c == 17);
    checkLanes(tag);
  endtask

  // Runs one sequence from cycle 0 up to last_cycle. With noisy set, spurious start pulses
  // and base changes are driven while the sequence runs; with chain set, start is raised in
  // cycle 19 with the next bases.
  task automatic applyStimulus(input logic [15:0] p, input logic [15:0] m, input bit pre_started,
                               input bit noisy, input bit chain, input logic [15:0] np,
                               input logic [15:0] nm, input int last_cycle);
    if (!pre_started) begin
      @(negedge clk);
      start = 1'b1;
      pxl_base = p;
      mul_base = m;
    end
    for (int c = 0; c <= last_cycle; c++) begin
      @(negedge clk);
      if (c <= 18) checkCycle(c, p, m);
      else         checkIdle("c19");
      start = 1'b0;
      if (c <= 18 && noisy) begin
        start    = (c == 3 || c == 18 || $urandom_range(0, 3) == 0);
        pxl_base = 16'($urandom);
        mul_base = 16'($urandom);
      end
      if (c == 19 && chain) begin
        start    = 1'b1;
        pxl_base = np;
        mul_base = nm;
      end
    end
    if (last_cycle >= 19 && !chain) start = 1'b0;
  endtask

  initial begin
    logic [15:0] p, m, np, nm;
    bit          chained;
    logic [31:0] seed_words [8];
    seed_words = '{32'h416D5267, 32'h416D5263, 32'h415D5267, 32'h426D5267,
                   32'h416D5367, 32'h416C5263, 32'h415D5267, 32'h426D506B};
    for (int a = 0; a < 65536; a++) mem[a] = $urandom;
    for (int i = 0; i < 8; i++) begin
      mem[i] = seed_words[i];
      mem['h100 + i] = seed_words[i % 4];
    end
    clearExpected();

    $display("[TB] reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdle("reset");
    rst = 1'b1;

    $display("[TB] full load");
    applyStimulus(16'h0000, 16'h0100, 0, 0, 0, 16'h0, 16'h0, 19);

    $display("[TB] ignored starts, chained start in cycle 19, base changes mid-sequence");
    p = 16'($urandom); m = 16'($urandom); np = 16'($urandom); nm = 16'($urandom);
    applyStimulus(p, m, 0, 1, 1, np, nm, 19);
    applyStimulus(np, nm, 1, 1, 0, 16'h0, 16'h0, 19);

    $display("[TB] address wrap");
    applyStimulus(16'hFFFC, 16'hFFFA, 0, 0, 0, 16'h0, 16'h0, 19);

    $display("[TB] reset mid-sequence");
    applyStimulus(16'h0040, 16'h0080, 0, 0, 0, 16'h0, 16'h0, 7);
    rst = 1'b0;
    @(negedge clk);
    clearExpected();
    checkIdle("abort_c8");
    rst = 1'b1;
    @(negedge clk);
    checkIdle("abort_c9");
    applyStimulus(16'h0040, 16'h0080, 0, 0, 0, 16'h0, 16'h0, 19);

    $display("[TB] overlapping regions");
    applyStimulus(16'h0200, 16'h0204, 0, 0, 0, 16'h0, 16'h0, 19);

    $display("[TB] random sequences");
    chained = 0;
    p = 16'($urandom); m = 16'($urandom);
    for (int s = 0; s < 10; s++) begin
      np = 16'($urandom); nm = 16'($urandom);
      applyStimulus(p, m, chained, $urandom_range(0, 1) == 1,
                    (s < 9) && ($urandom_range(0, 1) == 1), np, nm, 19);
      chained = (start == 1'b1);
      p = np; m = nm;
    end

    @(negedge clk);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
